lfsr4_checker: RTL and testbench

//   Receive-side PRBS checker for the lfsr4 generator's 4-bit LFSR state stream.

---
 rtl/lfsr4_checker.sv | 132 +++++++++++++
 tb/tb_lfsr4_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr4_checker.sv
// Receive-side PRBS checker: locks onto a 4-bit LFSR state stream, flywheels its own predictor,
// flags and counts mismatches while locked, and drops lock after repeated misses.
module lfsr4_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 2,
  parameter int               ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck_zero
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_seed, w_seed_nxt;
  logic             r_seed_vld, w_seed_vld_nxt;
  logic [7:0]       r_match_run, w_match_run_nxt;
  logic [7:0]       r_miss_run, w_miss_run_nxt;
  logic [WIDTH-1:0] r_expected, w_expected_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
  logic             r_stuck, w_stuck_nxt;
  logic             r_last_zero, w_last_zero_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_seed      <= '0;
      r_seed_vld  <= 1'b0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_expected  <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_stuck     <= 1'b0;
      r_last_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seed      <= w_seed_nxt;
      r_seed_vld  <= w_seed_vld_nxt;
      r_match_run <= w_match_run_nxt;
      r_miss_run  <= w_miss_run_nxt;
      r_expected  <= w_expected_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
      r_stuck     <= w_stuck_nxt;
      r_last_zero <= w_last_zero_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_seed_nxt      = r_seed;
    w_seed_vld_nxt  = r_seed_vld;
    w_match_run_nxt = r_match_run;
    w_miss_run_nxt  = r_miss_run;
    w_expected_nxt  = r_expected;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = r_err_count;
    w_stuck_nxt     = r_stuck;
    w_last_zero_nxt = r_last_zero;

    if (en) begin
      w_last_zero_nxt = (din == '0);
      if (din != '0)
        w_stuck_nxt = 1'b0;
      else if (r_last_zero)
        w_stuck_nxt = 1'b1;

      case (r_state)
        SEARCH: begin
          // Zero is excluded explicitly: it is a fixed point of the LFSR, so 0->0 would "match".
          if (r_seed_vld && din != '0 && din == f_next(r_seed)) begin
            w_match_run_nxt = r_match_run + 8'd1;
            if (int'(r_match_run) + 1 >= LOCK_CNT) begin
              w_state_nxt    = LOCKED;
              w_expected_nxt = f_next(din);
              w_miss_run_nxt = '0;
            end
          end else begin
            w_match_run_nxt = '0;
          end
          w_seed_nxt     = din;
          w_seed_vld_nxt = 1'b1;
        end
        LOCKED: begin
          if (din == r_expected) begin
            w_miss_run_nxt = '0;
            w_expected_nxt = f_next(r_expected);
          end else begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_count != '1)
              w_err_count_nxt = r_err_count + 1'b1;
            w_miss_run_nxt = r_miss_run + 8'd1;
            if (int'(r_miss_run) + 1 >= LOSS_CNT) begin
              w_state_nxt     = SEARCH;
              w_seed_nxt      = din;
              w_seed_vld_nxt  = 1'b1;
              w_match_run_nxt = '0;
            end else begin
              // Flywheel: the predictor is never reseeded from din while locked.
              w_expected_nxt = f_next(r_expected);
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end

    if (clr_err)
      w_err_count_nxt = '0;
  end

  assign locked     = (r_state == LOCKED);
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign stuck_zero = r_stuck;

endmodule

// File: tb/tb_lfsr4_checker.sv
// Directed plus randomized bench for lfsr4_checker, checked against a sequence-table reference model.
module tb_lfsr4_checker;

  logic       clk = 1'b0;
  logic       reset, en, clr_err;
  logic [3:0] din;
  logic       locked, err_pulse, stuck_zero;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  lfsr4_checker dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .stuck_zero(stuck_zero)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Maximal-length state sequence for taps 1100, starting at 0001.
  logic [3:0] seq [15];

  bit         m_locked, m_seed_vld, m_pulse, m_stuck, m_lastz;
  logic [3:0] m_seed;
  int         m_match, m_miss, m_exp, m_cnt;
  int         p;

  function automatic int pos(input logic [3:0] v);
    for (int i = 0; i < 15; i++)
      if (seq[i] == v) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_locked = 0; m_seed_vld = 0; m_pulse = 0; m_stuck = 0; m_lastz = 0;
    m_seed = 0; m_match = 0; m_miss = 0; m_exp = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] d, input bit c);
    m_pulse = 0;
    if (e) begin
      if (!m_locked) begin
        if (m_seed_vld && d != 0 && pos(m_seed) >= 0 && d == seq[(pos(m_seed) + 1) % 15]) begin
          m_match++;
          if (m_match >= 3) begin
            m_locked = 1;
            m_exp    = (pos(d) + 1) % 15;
            m_miss   = 0;
          end
        end else m_match = 0;
        m_seed = d; m_seed_vld = 1;
      end else begin
        if (d == seq[m_exp]) m_miss = 0;
        else begin
          m_pulse = 1;
          if (m_cnt < 255) m_cnt++;
          m_miss++;
          if (m_miss >= 2) begin
            m_locked = 0; m_seed = d; m_seed_vld = 1; m_match = 0;
          end
        end
        if (m_locked) m_exp = (m_exp + 1) % 15;
      end
      if (d != 0) m_stuck = 0;
      else if (m_lastz) m_stuck = 1;
      m_lastz = (d == 0);
    end
    if (c) m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},     {7'd0, locked},     {7'd0, m_locked});
    chk({tag, ".err_pulse"},  {7'd0, err_pulse},  {7'd0, m_pulse});
    chk({tag, ".err_count"},  err_count,          m_cnt[7:0]);
    chk({tag, ".stuck_zero"}, {7'd0, stuck_zero}, {7'd0, m_stuck});
  endtask

  task automatic cyc(input bit e, input logic [3:0] d, input bit c);
    en = e; din = d; clr_err = c;
    @(posedge clk);
    model_step(e, d, c);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic send_ok();
    cyc(1'b1, seq[p], 1'b0);
    p = (p + 1) % 15;
  endtask

  task automatic send_bad(input bit c);
    cyc(1'b1, seq[p] ^ 4'($urandom_range(1, 15)), c);
    p = (p + 1) % 15;
  endtask

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    reset = 1'b1; en = 1'b0; din = 4'h0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Acquire lock on 0001,0010,0100,1001.
    p = 0;
    repeat (4) send_ok();
    chk("t1.locked", {7'd0, locked}, 8'd1);
    chk("t1.err_count", err_count, 8'd0);

    // Full period with random idle gaps: no errors.
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 4'($urandom), 1'b0);
      send_ok();
    end
    chk("t2.locked", {7'd0, locked}, 8'd1);

    // 0000 in place of 0011, then the correct 0110.
    cyc(1'b1, 4'h0, 1'b0);
    p = (p + 1) % 15;
    chk("t3.err_pulse", {7'd0, err_pulse}, 8'd1);
    chk("t3.err_count", err_count, 8'd1);
    send_ok();
    chk("t3.locked", {7'd0, locked}, 8'd1);

    // Two consecutive misses drop lock; the stream then relocks.
    send_bad(1'b0);
    send_bad(1'b0);
    chk("t4.err_count", err_count, 8'd3);
    chk("t4.unlocked", {7'd0, locked}, 8'd0);
    repeat (4) send_ok();
    chk("t4.relocked", {7'd0, locked}, 8'd1);

    // Alternate miss/match to stay locked while saturating the counter.
    for (int i = 0; i < 260; i++) begin
      send_bad(1'b0);
      send_ok();
    end
    chk("t5.saturated", err_count, 8'hFF);
    send_bad(1'b1);
    chk("t5.clr_wins", err_count, 8'd0);

    // Random mix of good, bad, idle and clear.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)       cyc(1'b0, 4'($urandom), ($urandom_range(0, 7) == 0));
      else if (r == 2) send_bad(($urandom_range(0, 15) == 0));
      else if (r == 3) cyc(1'b1, 4'h0, 1'b0);
      else             send_ok();
    end

    // Stuck-at-zero detection.
    cyc(1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'h0, 1'b0);
    chk("t6.stuck_set", {7'd0, stuck_zero}, 8'd1);
    cyc(1'b1, 4'h1, 1'b0);
    chk("t6.stuck_clr", {7'd0, stuck_zero}, 8'd0);

    // Relock, make a counted error, then reset asynchronously mid-cycle.
    p = 0;
    repeat (8) send_ok();
    chk("t6.locked", {7'd0, locked}, 8'd1);
    send_bad(1'b0);
    chk("t6.err_pulse", {7'd0, err_pulse}, 8'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 4'h1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
